stepmotor_seq: RTL and testbench

Parametrised step-sequencer for 4-phase unipolar stepper motors: accepts a move command (direction, step count, half/full-step mode, step period), drives the coil pattern, tracks absolute position and reports completion. It replaces the free-running enable-gated stepper driver in the elevator car-drive path. The floor controller issues one command per travel segment and waits for `done`.

---
 rtl/stepmotor_seq.sv | 122 ++++++++++++
 tb/tb_stepmotor_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepmotor_seq.sv
// Step sequencer for 4-phase unipolar steppers: runs one move command at a time,
// drives the coil pattern, tracks absolute half-step position and pulses done.
module stepmotor_seq #(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned POS_W    = 24,
  parameter bit          HOLD     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic                cmd_half,
  input  logic [CNT_W-1:0]    cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [3:0]          step_drive,
  output logic                busy,
  output logic                done,
  output logic [POS_W-1:0]    pos
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [2:0]          phase;
  logic                dirQ;
  logic                halfQ;
  logic [CNT_W-1:0]    remaining;
  logic [PERIOD_W-1:0] periodQ;
  logic [PERIOD_W-1:0] divCnt;

  logic [2:0]          stride;
  logic [2:0]          phaseNext;
  logic [POS_W-1:0]    posNext;
  logic                termCnt;

  // Coil pattern for each of the eight half-step phases.
  function automatic logic [3:0] coilPattern(input logic [2:0] ph);
    case (ph)
      3'd0:    coilPattern = 4'b0001;
      3'd1:    coilPattern = 4'b0011;
      3'd2:    coilPattern = 4'b0010;
      3'd3:    coilPattern = 4'b0110;
      3'd4:    coilPattern = 4'b0100;
      3'd5:    coilPattern = 4'b1100;
      3'd6:    coilPattern = 4'b1000;
      default: coilPattern = 4'b1001;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);

  // Next phase/position for the step that would fire this cycle; phase wraps mod 8.
  always_comb begin
    stride    = halfQ ? 3'd1 : 3'd2;
    phaseNext = dirQ ? (phase - stride) : (phase + stride);
    posNext   = dirQ ? (pos - POS_W'(stride)) : (pos + POS_W'(stride));
    termCnt   = (divCnt == (periodQ - PERIOD_W'(1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      phase      <= 3'd0;
      dirQ       <= 1'b0;
      halfQ      <= 1'b0;
      remaining  <= '0;
      periodQ    <= '0;
      divCnt     <= '0;
      step_drive <= 4'b0000;
      pos        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dirQ      <= cmd_dir;
            halfQ     <= cmd_half;
            remaining <= cmd_steps;
            periodQ   <= (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
            divCnt    <= '0;
            if (cmd_steps != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort takes priority over a coincident terminal count.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!HOLD) step_drive <= 4'b0000;
          end else if (termCnt) begin
            divCnt    <= '0;
            phase     <= phaseNext;
            pos       <= posNext;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              step_drive <= HOLD ? coilPattern(phaseNext) : 4'b0000;
            end else begin
              step_drive <= coilPattern(phaseNext);
            end
          end else begin
            divCnt <= divCnt + PERIOD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepmotor_seq.sv
// Self-checking bench for stepmotor_seq: a HOLD=1 wide-position instance and a
// HOLD=0 4-bit-position instance share stimulus and are checked against an arithmetic model.
module tb_stepmotor_seq;

  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned POS_W    = 24;
  localparam int unsigned POS_W2   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_dir;
  logic                cmd_half;
  logic [CNT_W-1:0]    cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;
  logic                abort;

  logic                cmd_ready, busy, done;
  logic [3:0]          step_drive;
  logic [POS_W-1:0]    pos;
  logic                cmd_ready2, busy2, done2;
  logic [3:0]          step_drive2;
  logic [POS_W2-1:0]   pos2;

  int checks = 0;
  int errors = 0;

  // Reference state: phase index, unbounded position, last energised pattern.
  int         phaseM = 0;
  longint     posM = 0;
  logic [3:0] lastDrive = 4'b0000;

  stepmotor_seq #(.PERIOD_W(PERIOD_W), .CNT_W(CNT_W), .POS_W(POS_W), .HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_steps(cmd_steps),
    .cmd_period(cmd_period), .abort(abort), .step_drive(step_drive),
    .busy(busy), .done(done), .pos(pos)
  );

  stepmotor_seq #(.PERIOD_W(PERIOD_W), .CNT_W(CNT_W), .POS_W(POS_W2), .HOLD(1'b0)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_steps(cmd_steps),
    .cmd_period(cmd_period), .abort(abort), .step_drive(step_drive2),
    .busy(busy2), .done(done2), .pos(pos2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] pat(input int ph);
    case (ph)
      0: return 4'b0001;
      1: return 4'b0011;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0100;
      5: return 4'b1100;
      6: return 4'b1000;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic int mod8(input int x);
    return ((x % 8) + 8) % 8;
  endfunction

  // Issues one command (accepted at the next edge) and checks every cycle through
  // the completion (or abort) cycle. abortAt>0: abort sampled at that edge after
  // acceptance; abortAt<0: abort held high on the accept edge only (must be ignored).
  task automatic do_move(input string tag, input bit dir, input bit half, input int n,
                         input int period, input int abortAt, input bit garbage);
    int p, s, last, k, ph;
    longint posE;
    logic expBusy, expDone;
    logic [3:0] expDrv, expDrv2;
    p = (period == 0) ? 1 : period;
    s = half ? 1 : 2;
    if (dir) s = -s;
    last = (abortAt > 0) ? abortAt : n * p;
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_half   = half;
    cmd_steps  = CNT_W'(n);
    cmd_period = PERIOD_W'(period);
    abort      = (abortAt < 0);
    k = 0; ph = phaseM; posE = posM;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      k = (abortAt > 0 && t == abortAt) ? (t - 1) / p : t / p;
      if (k > n) k = n;
      ph      = mod8(phaseM + s * k);
      posE    = posM + longint'(s * k);
      expBusy = (abortAt > 0) ? (t < abortAt) : (t < n * p);
      expDone = (abortAt <= 0) && (t == n * p);
      expDrv  = (k > 0) ? pat(ph) : lastDrive;
      expDrv2 = (k > 0 && expBusy) ? pat(ph) : 4'b0000;
      checks++;
      if ({busy, done, cmd_ready, step_drive} !== {expBusy, expDone, ~expBusy, expDrv}) begin
        errors++;
        $display("FAIL %s t=%0d busy/done/ready/drive got %b required %b", tag, t,
                 {busy, done, cmd_ready, step_drive}, {expBusy, expDone, ~expBusy, expDrv});
      end
      checks++;
      if (pos !== POS_W'(posE)) begin
        errors++;
        $display("FAIL %s t=%0d pos got %0d required %0d", tag, t, $signed(pos), posE);
      end
      checks++;
      if ({busy2, done2, cmd_ready2, step_drive2, pos2} !==
          {expBusy, expDone, ~expBusy, expDrv2, POS_W2'(posE)}) begin
        errors++;
        $display("FAIL %s t=%0d hold0 busy/done/ready/drive/pos got %b required %b", tag, t,
                 {busy2, done2, cmd_ready2, step_drive2, pos2},
                 {expBusy, expDone, ~expBusy, expDrv2, POS_W2'(posE)});
      end
      if (t < last) begin
        if (garbage) begin
          cmd_valid  = 1'($urandom_range(0, 1));
          cmd_dir    = 1'($urandom_range(0, 1));
          cmd_half   = 1'($urandom_range(0, 1));
          cmd_steps  = CNT_W'($urandom_range(0, 9));
          cmd_period = PERIOD_W'($urandom_range(0, 5));
        end
        if (abortAt > 0 && t + 1 == abortAt) abort = 1'b1;
      end
    end
    phaseM = ph;
    posM   = posE;
    if (k > 0) lastDrive = pat(ph);
  endtask

  task automatic check_idle(input string tag);
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, cmd_ready, step_drive} !== {3'b001, lastDrive}) begin
      errors++;
      $display("FAIL %s idle busy/done/ready/drive got %b required %b", tag,
               {busy, done, cmd_ready, step_drive}, {3'b001, lastDrive});
    end
    checks++;
    if (pos !== POS_W'(posM)) begin
      errors++;
      $display("FAIL %s idle pos got %0d required %0d", tag, $signed(pos), posM);
    end
    checks++;
    if ({busy2, done2, cmd_ready2, step_drive2, pos2} !== {3'b001, 4'b0000, POS_W2'(posM)}) begin
      errors++;
      $display("FAIL %s idle hold0 got %b required %b", tag,
               {busy2, done2, cmd_ready2, step_drive2, pos2}, {3'b001, 4'b0000, POS_W2'(posM)});
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    phaseM = 0; posM = 0; lastDrive = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_half = 1'b1;
    cmd_steps = CNT_W'(3); cmd_period = PERIOD_W'(1); abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, cmd_ready, step_drive, pos} !== {3'b001, 4'b0000, 24'd0}) begin
      errors++;
      $display("FAIL reset state got %b required %b", {busy, done, cmd_ready, step_drive, pos},
               {3'b001, 4'b0000, 24'd0});
    end
    checks++;
    if ({busy2, done2, cmd_ready2, step_drive2, pos2} !== {3'b001, 4'b0000, 4'd0}) begin
      errors++;
      $display("FAIL reset hold0 state got %b required %b",
               {busy2, done2, cmd_ready2, step_drive2, pos2}, {3'b001, 4'b0000, 4'd0});
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("reset_release");
  endtask

  task automatic test_half_forward();
    do_move("half_fwd", 1'b0, 1'b1, 3, 4, 0, 1'b0);
    checks++;
    if ({step_drive, pos} !== {4'b0110, 24'd3}) begin
      errors++;
      $display("FAIL half_fwd final drive/pos got %b required %b", {step_drive, pos}, {4'b0110, 24'd3});
    end
    check_idle("half_fwd");
  endtask

  task automatic test_full_reverse();
    apply_reset();
    do_move("full_fwd", 1'b0, 1'b0, 4, 2, 0, 1'b0);
    checks++;
    if ({step_drive, pos} !== {4'b0001, 24'd8}) begin
      errors++;
      $display("FAIL full_fwd final drive/pos got %b required %b", {step_drive, pos}, {4'b0001, 24'd8});
    end
    do_move("half_rev", 1'b1, 1'b1, 8, 1, 0, 1'b0);
    checks++;
    if ({step_drive, pos} !== {4'b0001, 24'd0}) begin
      errors++;
      $display("FAIL half_rev final drive/pos got %b required %b", {step_drive, pos}, {4'b0001, 24'd0});
    end
    check_idle("half_rev");
  endtask

  task automatic test_abort();
    longint p0;
    p0 = posM;
    do_move("abort", 1'b0, 1'b1, 5, 3, 6, 1'b0);
    checks++;
    if (pos !== POS_W'(p0 + 1)) begin
      errors++;
      $display("FAIL abort pos got %0d required %0d", $signed(pos), p0 + 1);
    end
    check_idle("abort");
    do_move("abort_idle", 1'b1, 1'b0, 2, 2, -1, 1'b0);
    check_idle("abort_idle");
  endtask

  task automatic test_zero_steps();
    do_move("zero_steps", 1'b0, 1'b1, 0, 3, 0, 1'b0);
    check_idle("zero_steps");
    do_move("period0", 1'b1, 1'b0, 2, 0, 0, 1'b0);
    check_idle("period0");
  endtask

  task automatic test_pos_wrap();
    apply_reset();
    do_move("wrap_pre", 1'b0, 1'b1, 7, 1, 0, 1'b0);
    checks++;
    if (pos2 !== 4'd7) begin
      errors++;
      $display("FAIL wrap_pre pos2 got %0d required 7", pos2);
    end
    do_move("wrap", 1'b0, 1'b1, 1, 2, 0, 1'b0);
    checks++;
    if ({pos2, pos} !== {4'b1000, 24'd8}) begin
      errors++;
      $display("FAIL wrap pos2/pos got %b required %b", {pos2, pos}, {4'b1000, 24'd8});
    end
    check_idle("wrap");
  endtask

  task automatic test_reset_mid();
    do_move("garbage_run", 1'b0, 1'b1, 4, 3, 0, 1'b1);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_half = 1'b1;
    cmd_steps = CNT_W'(6); cmd_period = PERIOD_W'(2);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({busy, pos, step_drive} !== {1'b1, POS_W'(posM + 2), pat(mod8(phaseM + 2))}) begin
      errors++;
      $display("FAIL pre_rst busy/pos/drive got %b required %b", {busy, pos, step_drive},
               {1'b1, POS_W'(posM + 2), pat(mod8(phaseM + 2))});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, step_drive, pos, busy2, step_drive2, pos2} !== {1'b0, 4'b0000, 24'd0, 1'b0, 4'b0000, 4'd0}) begin
      errors++;
      $display("FAIL mid_rst got %b required %b", {busy, step_drive, pos, busy2, step_drive2, pos2},
               {1'b0, 4'b0000, 24'd0, 1'b0, 4'b0000, 4'd0});
    end
    @(negedge clk);
    rst = 1'b1;
    phaseM = 0; posM = 0; lastDrive = 4'b0000;
    check_idle("mid_rst");
  endtask

  task automatic test_back_to_back();
    do_move("b2b_a", 1'b0, 1'b0, 3, 1, 0, 1'b0);
    do_move("b2b_b", 1'b1, 1'b1, 2, 3, 0, 1'b1);
    do_move("b2b_c", 1'b0, 1'b1, 0, 2, 0, 1'b0);
    do_move("b2b_d", 1'b1, 1'b0, 4, 2, 5, 1'b0);
    do_move("b2b_e", 1'b0, 1'b1, 2, 2, 0, 1'b0);
    check_idle("b2b");
  endtask

  task automatic test_random();
    int n, period, p, ab, r;
    bit dir, half;
    for (int i = 0; i < 40; i++) begin
      dir    = 1'($urandom_range(0, 1));
      half   = 1'($urandom_range(0, 1));
      n      = int'($urandom_range(0, 6));
      period = int'($urandom_range(0, 4));
      p      = (period == 0) ? 1 : period;
      r      = int'($urandom_range(0, 5));
      ab     = 0;
      if (n > 0 && r == 0) ab = int'($urandom_range(1, n * p));
      else if (r == 1) ab = -1;
      do_move($sformatf("rand%0d", i), dir, half, n, period, ab, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) check_idle($sformatf("rand%0d", i));
    end
    check_idle("rand_end");
  endtask

  initial begin
    test_reset();
    test_half_forward();
    test_full_reverse();
    test_abort();
    test_zero_steps();
    test_pos_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
